// File: rtl/step_sequencer.sv
// step_sequencer: button front-end for the up/down counter datapath.
//   Synchronises and debounces the raw sum (up) and res (down) buttons, turns each
//   debounced release into one step request, cancels simultaneous up/down requests,
//   saturates at 0..MAX_VAL and offers steps to the counter over valid/ready. A
//   shadow copy of the committed count and its end-stop flags is kept here.
//
// Optional feature: define AUTOREPEAT_EN to add hold-to-repeat on each button.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       synchronous active-high reset
//   sum_i         raw up button (asynchronous, bouncy)
//   res_i         raw down button (asynchronous, bouncy)
//   step_ready_i  counter accepts the offered step this cycle
//   step_valid_o  step command offered
//   step_dir_o    1 = increment, 0 = decrement; meaningful while step_valid_o
//   count_o       committed count shadow
//   at_max_o      count_o == MAX_VAL
//   at_min_o      count_o == 0
module step_sequencer #(
   parameter int unsigned WIDTH        = 3,
   parameter int unsigned MAX_VAL      = 7,
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned REPEAT_DLY   = 64,
   parameter int unsigned REPEAT_PER   = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             sum_i,
   input  logic             res_i,
   input  logic             step_ready_i,
   output logic             step_valid_o,
   output logic             step_dir_o,
   output logic [WIDTH-1:0] count_o,
   output logic             at_max_o,
   output logic             at_min_o
);

   // Elaboration-time parameter sanity checks.
   if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYC must be at least 2");
   end
   if (MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("MAX_VAL does not fit in WIDTH bits");
   end
   if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_repeat
      $error("REPEAT_DLY and REPEAT_PER must be at least 1");
   end

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYC);
   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

   typedef enum logic {StIdle, StOffer} state_e;

   // Bit 0 = sum (up), bit 1 = res (down) throughout.
   logic [1:0]          meta_q, sync_q;
   logic [1:0]          db_q, db_d;
   logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]          rel;
   logic [1:0]          ev;
   logic [1:0]          pend_q, pend_d;
   state_e              state_q, state_d;
   logic                dir_q, dir_d;
   logic [WIDTH-1:0]    count_q, count_d;
   logic                at_max_q, at_max_d;
   logic                at_min_q, at_min_d;

   // Debounce: the level flips once the synced input has differed for DEBOUNCE_CYC
   // consecutive cycles. A 1->0 flip is a release event, raised in the flip cycle.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      rel      = '0;
      for (int b = 0; b < 2; b++) begin
         if (sync_q[b] != db_q[b]) begin
            if (db_cnt_q[b] == DbW'(DEBOUNCE_CYC - 1)) begin
               db_d[b]     = sync_q[b];
               db_cnt_d[b] = '0;
               rel[b]      = db_q[b];
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
            end
         end else begin
            db_cnt_d[b] = '0;
         end
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int unsigned RptMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int unsigned RptW   = $clog2(RptMax + 1);

   logic [1:0][RptW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [1:0]           rpt_first_q, rpt_first_d;  // still waiting for the first repeat
   logic [1:0]           rpt;
   logic                 both_held;

   assign both_held = &db_q;

   always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      rpt         = '0;
      for (int b = 0; b < 2; b++) begin
         if (db_q[b]) begin
            if (rpt_cnt_q[b] == RptW'((rpt_first_q[b] ? REPEAT_DLY : REPEAT_PER) - 1)) begin
               rpt_cnt_d[b]   = '0;
               rpt_first_d[b] = 1'b0;
               rpt[b]         = ~both_held;
            end else begin
               rpt_cnt_d[b] = rpt_cnt_q[b] + RptW'(1);
            end
         end else begin
            rpt_cnt_d[b]   = '0;
            rpt_first_d[b] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= '1;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
      end
   end

   assign ev = rel | rpt;
`else
   assign ev = rel;
`endif

   // Arbitration and handshake. Events arriving this cycle are merged with the
   // pending slots so an idle sequencer offers the step on the very next cycle.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q | ev;
      dir_d   = dir_q;
      count_d = count_q;
      case (state_q)
         StIdle: begin
            if (pend_d[0] && pend_d[1]) begin
               pend_d = '0;  // opposite requests cancel
            end else if (pend_d[0]) begin
               pend_d[0] = 1'b0;
               if (count_q != MaxVal) begin
                  state_d = StOffer;
                  dir_d   = 1'b1;
               end
            end else if (pend_d[1]) begin
               pend_d[1] = 1'b0;
               if (count_q != '0) begin
                  state_d = StOffer;
                  dir_d   = 1'b0;
               end
            end
         end
         StOffer: begin
            if (step_ready_i) begin
               count_d = dir_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      at_max_d = (count_d == MaxVal);
      at_min_d = (count_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q   <= '0;
         sync_q   <= '0;
         db_q     <= '0;
         db_cnt_q <= '0;
         pend_q   <= '0;
         state_q  <= StIdle;
         dir_q    <= 1'b0;
         count_q  <= '0;
         at_max_q <= (MaxVal == '0);
         at_min_q <= 1'b1;
      end else begin
         meta_q   <= {res_i, sum_i};
         sync_q   <= meta_q;
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
         pend_q   <= pend_d;
         state_q  <= state_d;
         dir_q    <= dir_d;
         count_q  <= count_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
      end
   end

   assign step_valid_o = (state_q == StOffer);
   assign step_dir_o   = dir_q;
   assign count_o      = count_q;
   assign at_max_o     = at_max_q;
   assign at_min_o     = at_min_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer: directed scenarios followed by randomized button
// operations, checked against a release/repeat-level model of the sequencer.
module tb_step_sequencer;

   localparam int unsigned W    = 3;
   localparam int unsigned MAXV = 7;
   localparam int unsigned DB   = 4;
   localparam int unsigned RDLY = 8;
   localparam int unsigned RPER = 4;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b1;
   logic         sum_i = 1'b0;
   logic         res_i = 1'b0;
   logic         step_ready_i = 1'b1;
   logic         step_valid_o;
   logic         step_dir_o;
   logic [W-1:0] count_o;
   logic         at_max_o;
   logic         at_min_o;

   always #5 clk_i = ~clk_i;

   step_sequencer #(
      .WIDTH       (W),
      .MAX_VAL     (MAXV),
      .DEBOUNCE_CYC(DB),
      .REPEAT_DLY  (RDLY),
      .REPEAT_PER  (RPER)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .sum_i       (sum_i),
      .res_i       (res_i),
      .step_ready_i(step_ready_i),
      .step_valid_o(step_valid_o),
      .step_dir_o  (step_dir_o),
      .count_o     (count_o),
      .at_max_o    (at_max_o),
      .at_min_o    (at_min_o)
   );

   int total = 0;
   int bad   = 0;
   int cnt_m = 0;       // model count
   bit exp_q[$];        // expected directions of accepted steps, in order
   bit rand_rdy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
         if (rand_rdy) step_ready_i = ($urandom_range(0, 3) != 0);
      end
   endtask

   // n step requests in one direction, with saturation against the model count.
   task automatic model_events(input bit up, input int n);
      for (int i = 0; i < n; i++) begin
         if (up) begin
            if (cnt_m < int'(MAXV)) begin
               cnt_m++;
               exp_q.push_back(1'b1);
            end
         end else if (cnt_m > 0) begin
            cnt_m--;
            exp_q.push_back(1'b0);
         end
      end
   endtask

   // Requests produced by one button held for `hold` debounced cycles, then released.
   function automatic int events_for_hold(input int hold);
      int n;
      n = 1;
`ifdef AUTOREPEAT_EN
      if (hold >= int'(RDLY)) n += (hold - int'(RDLY)) / int'(RPER) + 1;
`endif
      return n;
   endfunction

   task automatic press(input bit up, input bit dn, input int hold);
      if (up != dn) model_events(up, events_for_hold(hold));
      sum_i = up;
      res_i = dn;
      tick(hold);
      sum_i = 1'b0;
      res_i = 1'b0;
   endtask

   task automatic bounce();
      for (int i = 0; i < 5; i++) begin
         sum_i = 1'b1;
         tick(2);
         sum_i = 1'b0;
         tick(2);
      end
   endtask

   task automatic settle(input string tag);
      int quiet;
      int guard;
      quiet = 0;
      guard = 0;
      tick(DB + 6);
      while (quiet < 3 && guard < 300) begin
         tick();
         quiet = step_valid_o ? 0 : quiet + 1;
         guard++;
      end
      check({tag, "_quiet"}, quiet >= 3, 1);
      check({tag, "_count"}, count_o, cnt_m);
      check({tag, "_at_max"}, at_max_o, cnt_m == int'(MAXV));
      check({tag, "_at_min"}, at_min_o, cnt_m == 0);
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic do_reset(input int n);
      reset_i = 1'b1;
      sum_i   = 1'b0;
      res_i   = 1'b0;
      cnt_m   = 0;
      exp_q.delete();
      tick(n);
      reset_i = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = step_valid_o;
      end
      check({tag, "_valid_seen"}, found, 1);
   endtask

   // Handshake monitor: every accepted step must be the next expected one, and an
   // offer that is not accepted must stay put with the same direction.
   logic prev_stall = 1'b0;
   logic prev_dir   = 1'b0;
   always @(negedge clk_i) begin
      if (reset_i) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", step_valid_o, 1);
            check("stall_dir", step_dir_o, prev_dir);
         end
         if (step_valid_o && step_ready_i) begin
            check("step_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("step_dir", step_dir_o, exp_q.pop_front());
         end
         prev_stall <= step_valid_o && !step_ready_i;
         prev_dir   <= step_dir_o;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      do_reset(4);
      check("rst_valid", step_valid_o, 0);
      check("rst_dir", step_dir_o, 0);
      check("rst_count", count_o, 0);
      check("rst_at_min", at_min_o, 1);
      check("rst_at_max", at_max_o, 0);

      // One clean press: single pulse, count visible the cycle after acceptance.
      model_events(1'b1, 1);
      sum_i = 1'b1;
      tick(10);
      sum_i = 1'b0;
      wait_valid("t1");
      check("t1_dir", step_dir_o, 1);
      check("t1_count_before", count_o, 0);
      tick();
      check("t1_valid_drop", step_valid_o, 0);
      check("t1_count_after", count_o, 1);
      check("t1_at_min", at_min_o, 0);
      settle("t1");

      // Bounce shorter than the debounce window never produces a step.
      do_reset(3);
      bounce();
      settle("t2");

      // Saturation at the top.
      do_reset(3);
      for (int i = 0; i < 8; i++) begin
         press(1'b1, 1'b0, 6);
         settle("t3");
      end

      // Simultaneous releases cancel.
      do_reset(3);
      for (int i = 0; i < 3; i++) begin
         press(1'b1, 1'b0, 6);
         settle("t4_pre");
      end
      press(1'b1, 1'b1, 6);
      settle("t4");

      // Stalled offer with an opposite release queued behind it.
      step_ready_i = 1'b0;
      press(1'b1, 1'b0, 6);
      wait_valid("t5");
      check("t5_dir", step_dir_o, 1);
      press(1'b0, 1'b1, 6);
      tick(10);
      check("t5_valid_held", step_valid_o, 1);
      check("t5_dir_held", step_dir_o, 1);
      check("t5_count_held", count_o, 3);
      step_ready_i = 1'b1;
      settle("t5");

      // Reset during an offer drops it.
      step_ready_i = 1'b0;
      press(1'b1, 1'b0, 6);
      wait_valid("t5b");
      do_reset(2);
      check("t5b_valid", step_valid_o, 0);
      check("t5b_count", count_o, 0);
      check("t5b_at_min", at_min_o, 1);
      step_ready_i = 1'b1;
      settle("t5b");

      // Long hold: auto-repeat (when built in) saturates at the top.
      do_reset(3);
      press(1'b1, 1'b0, 34);
      settle("t6");

      // Reset while still holding: first repeat only (when built in), then cleared.
      do_reset(3);
`ifdef AUTOREPEAT_EN
      model_events(1'b1, 1);
`endif
      sum_i = 1'b1;
      tick(16);
      check("t6b_count_held", count_o, cnt_m);
      do_reset(3);
      check("t6b_valid", step_valid_o, 0);
      check("t6b_count", count_o, 0);
      check("t6b_at_min", at_min_o, 1);
      settle("t6b");

      // Randomized operations with a random ready pattern.
      rand_rdy = 1'b1;
      do_reset(2);
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 9);
         if (k <= 3)      press(1'b1, 1'b0, $urandom_range(5, 7));
         else if (k <= 6) press(1'b0, 1'b1, $urandom_range(5, 7));
         else if (k <= 8) press(1'b1, 1'b1, $urandom_range(5, 7));
         else             bounce();
         settle("rnd");
      end
      rand_rdy = 1'b0;
      step_ready_i = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
